// File: rtl/fp_div_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fp_div_arbiter
// Description : Round-robin arbiter/sequencer sharing one FP32 divider between
//               NUM_REQ requesters. Captures the winner's operands, pulses the
//               divider enable once, holds the operands for the whole divide
//               and routes Result/NaN back as a one-cycle response pulse.
//               Optional watchdog abort: define FP_DIV_ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_div_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ID_W        = 2,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ*32-1:0] req_a,
  input  logic [NUM_REQ*32-1:0] req_b,
  output logic [NUM_REQ-1:0]    gnt,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [31:0]           rsp_result,
  output logic                  rsp_nan,
  output logic                  rsp_timeout,
  output logic                  busy,
  output logic                  div_en,
  output logic [31:0]           div_a,
  output logic [31:0]           div_b,
  input  logic [31:0]           div_result,
  input  logic                  div_ready,
  input  logic                  div_nan
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t          r_state;
  logic [ID_W-1:0] r_rr_ptr;
  logic [ID_W-1:0] r_owner;
  logic [ID_W-1:0] w_win;
  logic [ID_W-1:0] w_ptr_nxt;
  logic            w_any;
  logic            w_done;
  logic [ID_W:0]   w_sum [NUM_REQ];
  logic [ID_W-1:0] w_idx [NUM_REQ];

`ifdef FP_DIV_ARB_TIMEOUT_EN
  localparam int          CNT_W  = $clog2(TIMEOUT_CYC + 1);
  localparam logic [31:0] C_QNAN = 32'h7FC0_0000;
  logic [CNT_W-1:0] r_wd_cnt;
`else
  assign rsp_timeout = 1'b0;
`endif

  // Elaboration-time guard against unsupported parameter combinations
  generate
    if (NUM_REQ < 2 || NUM_REQ > 8 || ID_W != $clog2(NUM_REQ) || TIMEOUT_CYC < 1) begin : g_param_check
      $error("fp_div_arbiter: illegal parameter set");
    end
  endgenerate

  // Search order table: entry k is requester (rr_ptr + k) mod NUM_REQ
  generate
    for (genvar k = 0; k < NUM_REQ; k++) begin : g_idx
      assign w_sum[k] = {1'b0, r_rr_ptr} + (ID_W+1)'(k);
      assign w_idx[k] = (w_sum[k] >= (ID_W+1)'(NUM_REQ)) ?
                        ID_W'(w_sum[k] - (ID_W+1)'(NUM_REQ)) : w_sum[k][ID_W-1:0];
    end
  endgenerate

  // Pick the first requesting index at or after rr_ptr (lowest offset wins)
  always_comb begin
    w_any = |req;
    w_win = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[w_idx[k]]) begin
        w_win = w_idx[k];
      end
    end
  end

  assign w_ptr_nxt = (w_win == ID_W'(NUM_REQ - 1)) ? '0 : w_win + ID_W'(1);
  assign w_done    = div_ready | div_nan;

  // Sequencer: grant, issue, wait for the divider, respond; all outputs registered
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_rr_ptr   <= '0;
      r_owner    <= '0;
      gnt        <= '0;
      rsp_valid  <= '0;
      rsp_result <= '0;
      rsp_nan    <= 1'b0;
      busy       <= 1'b0;
      div_en     <= 1'b0;
      div_a      <= '0;
      div_b      <= '0;
`ifdef FP_DIV_ARB_TIMEOUT_EN
      r_wd_cnt    <= '0;
      rsp_timeout <= 1'b0;
`endif
    end else begin
      gnt       <= '0;
      rsp_valid <= '0;
      div_en    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // busy stays high through the response cycle, drops here if nothing follows
          if (w_any) begin
            gnt[w_win] <= 1'b1;
            div_a      <= req_a[32*w_win +: 32];
            div_b      <= req_b[32*w_win +: 32];
            r_owner    <= w_win;
            r_rr_ptr   <= w_ptr_nxt;
            busy       <= 1'b1;
            r_state    <= S_ISSUE;
          end else begin
            busy <= 1'b0;
          end
        end
        S_ISSUE: begin
          div_en  <= 1'b1;
`ifdef FP_DIV_ARB_TIMEOUT_EN
          r_wd_cnt <= '0;
`endif
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          // Completion takes priority over a watchdog expiry in the same cycle
          if (w_done) begin
            rsp_result <= div_result;
            rsp_nan    <= div_nan;
`ifdef FP_DIV_ARB_TIMEOUT_EN
            rsp_timeout <= 1'b0;
`endif
            r_state    <= S_RESP;
          end
`ifdef FP_DIV_ARB_TIMEOUT_EN
          else if (r_wd_cnt == CNT_W'(TIMEOUT_CYC)) begin
            rsp_result  <= C_QNAN;
            rsp_nan     <= 1'b1;
            rsp_timeout <= 1'b1;
            r_state     <= S_RESP;
          end else begin
            r_wd_cnt <= r_wd_cnt + CNT_W'(1);
          end
`endif
        end
        S_RESP: begin
          // Always return to IDLE so the divider sees a gap before the next enable
          rsp_valid[r_owner] <= 1'b1;
          r_state            <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
